// File: rtl/dcpu_ctrl_if.sv
// -----------------------------------------------------------------------------
// dcpu_ctrl_if -- bundle between the DCPU control unit and its memory/datapath.
//
// Signals (direction as seen from the controller, i.e. the master modport):
//   i_mem_dat       in   8  memory read data, valid while i_mem_ack=1
//   i_mem_ack       in   1  memory completes the current request this cycle
//   o_mem_req       out  1  memory request
//   o_mem_we        out  1  request is a write (write data comes from the databus)
//   o_pc_sel        out  1  1 = memory address from o_pc, 0 = regfile address pair
//   o_pc            out 16  program counter
//   o_op            out  3  ALU operation select
//   o_load          out  1  regfile write strobe
//   o_load_reg_sel  out  4  regfile write destination
//   o_alu_l_sel     out  4  left ALU operand register
//   o_alu_r_sel     out  4  right ALU operand register
//   o_addr_sel      out  3  regfile address-pair select
//   o_dat_sel       out  1  1 = regfile write data from i_mem_dat, 0 = from ALU
//   o_halted        out  1  core stopped
// -----------------------------------------------------------------------------
interface dcpu_ctrl_if;
    logic [7:0]  i_mem_dat;
    logic        i_mem_ack;
    logic        o_mem_req;
    logic        o_mem_we;
    logic        o_pc_sel;
    logic [15:0] o_pc;
    logic [2:0]  o_op;
    logic        o_load;
    logic [3:0]  o_load_reg_sel;
    logic [3:0]  o_alu_l_sel;
    logic [3:0]  o_alu_r_sel;
    logic [2:0]  o_addr_sel;
    logic        o_dat_sel;
    logic        o_halted;

    // Controller side.
    modport master (
        input  i_mem_dat, i_mem_ack,
        output o_mem_req, o_mem_we, o_pc_sel, o_pc, o_op, o_load,
               o_load_reg_sel, o_alu_l_sel, o_alu_r_sel, o_addr_sel,
               o_dat_sel, o_halted
    );

    // Memory / datapath side.
    modport slave (
        output i_mem_dat, i_mem_ack,
        input  o_mem_req, o_mem_we, o_pc_sel, o_pc, o_op, o_load,
               o_load_reg_sel, o_alu_l_sel, o_alu_r_sel, o_addr_sel,
               o_dat_sel, o_halted
    );
endinterface

// File: rtl/dcpu_ctrl.sv
// -----------------------------------------------------------------------------
// dcpu_ctrl -- control unit of a small 16-register, 8-bit-memory CPU.
//
// Fetches a two-byte instruction {cls,dst}/{srcL,srcR} from consecutive PC
// addresses, then drives the regfile/ALU selects to execute it:
//   cls 0xxx  ALU   reg[dst] <= ALU_op(reg[srcL], reg[srcR]), op = cls[2:0]
//   cls 1000  LD    reg[dst] <= mem[addr pair srcR[2:0]]
//   cls 1001  ST    mem[addr pair srcR[2:0]] <= pass(reg[srcL])
//   cls 1111  HALT  stop until reset
//   others    NOP
//
// Ports:
//   i_clk    sole clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      dcpu_ctrl_if.master -- memory handshake and datapath controls
//
// Parameter:
//   RESET_PC  program counter value loaded on reset
// -----------------------------------------------------------------------------
module dcpu_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    dcpu_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        FETCH0,
        FETCH1,
        EXEC,
        MEM,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LD,
        CLS_ST,
        CLS_HALT,
        CLS_NOP
    } cls_t;

    function automatic cls_t classify(input logic [3:0] cls);
        cls_t c;
        if (!cls[3]) begin
            c = CLS_ALU;
        end else begin
            case (cls)
                4'b1000: c = CLS_LD;
                4'b1001: c = CLS_ST;
                4'b1111: c = CLS_HALT;
                default: c = CLS_NOP;
            endcase
        end
        return c;
    endfunction

    state_t      state;
    logic [15:0] pc;
    logic [7:0]  byte0;     // first instruction byte, held until byte1 arrives
    logic [15:0] ir;        // full instruction, written only when byte1 is accepted
    logic        mem_req;
    logic        mem_we;
    logic        pc_sel;
    logic        alu_load;  // one-cycle write strobe for ALU instructions
    logic        dat_sel;
    logic        halted;

    cls_t        ir_cls;
    cls_t        fetch_cls;
    logic        ack_ok;

    assign ir_cls    = classify(ir[15:12]);
    assign fetch_cls = classify(byte0[7:4]);
    // An ack only counts while a request is actually outstanding.
    assign ack_ok    = mem_req & bus.i_mem_ack;

    // NOTE: every register sits in one clocked block with non-blocking
    // assignments, so all next-state decisions read the same pre-edge values;
    // the asynchronous reset branch drops the request and strobes at once,
    // without waiting for a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= FETCH0;
            pc       <= RESET_PC;
            byte0    <= 8'h00;
            ir       <= 16'h0000;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            pc_sel   <= 1'b0;
            alu_load <= 1'b0;
            dat_sel  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                FETCH0: begin
                    // Also raises the very first request after reset release.
                    mem_req <= 1'b1;
                    pc_sel  <= 1'b1;
                    if (ack_ok) begin
                        byte0 <= bus.i_mem_dat;
                        pc    <= pc + 16'd1;
                        state <= FETCH1;
                    end
                end

                FETCH1: begin
                    if (ack_ok) begin
                        ir       <= {byte0, bus.i_mem_dat};
                        pc       <= pc + 16'd1;
                        mem_req  <= 1'b0;
                        alu_load <= (fetch_cls == CLS_ALU);
                        state    <= EXEC;
                    end
                end

                EXEC: begin
                    alu_load <= 1'b0;
                    case (ir_cls)
                        CLS_LD, CLS_ST: begin
                            mem_req <= 1'b1;
                            pc_sel  <= 1'b0;
                            mem_we  <= (ir_cls == CLS_ST);
                            dat_sel <= (ir_cls == CLS_LD);
                            state   <= MEM;
                        end
                        CLS_HALT: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        default: begin
                            // ALU and NOP both continue straight into the next fetch.
                            mem_req <= 1'b1;
                            pc_sel  <= 1'b1;
                            state   <= FETCH0;
                        end
                    endcase
                end

                MEM: begin
                    // Request stays up (address and we frozen) until acked; the
                    // next fetch request follows back-to-back.
                    if (ack_ok) begin
                        mem_we  <= 1'b0;
                        dat_sel <= 1'b0;
                        pc_sel  <= 1'b1;
                        state   <= FETCH0;
                    end
                end

                HALT: begin
                    // Absorbing: only reset leaves this state.
                end

                default: begin
                    state <= FETCH0;
                end
            endcase
        end
    end

    assign bus.o_mem_req      = mem_req;
    assign bus.o_mem_we       = mem_we;
    assign bus.o_pc_sel       = pc_sel;
    assign bus.o_pc           = pc;
    assign bus.o_halted       = halted;
    assign bus.o_dat_sel      = dat_sel;

    // Selects decode straight from ir, which only changes when byte1 is
    // accepted, so they hold from EXEC through MEM completion.
    assign bus.o_load_reg_sel = ir[11:8];
    assign bus.o_alu_l_sel    = ir[7:4];
    assign bus.o_alu_r_sel    = ir[3:0];
    assign bus.o_addr_sel     = ir[2:0];
    // ST passes reg[srcL] through the ALU with op 0; non-ALU classes use 0.
    assign bus.o_op           = (ir_cls == CLS_ALU) ? ir[14:12] : 3'b000;

    // NOTE: a load writes the regfile in the same cycle its ack arrives, so
    // this strobe is combinational on i_mem_ack rather than registered.
    assign bus.o_load = alu_load | ((state == MEM) && (ir_cls == CLS_LD) && ack_ok);

endmodule
